fifo_word_packer: RTL and testbench

Downstream drain stage for the byte FIFO. It pulls N-bit elements through the FIFO's read port (rd_en / data_out / status_empty) and packs K consecutive elements into one N*K-bit word. It presents that word on a valid/ready output interface to the next consumer. A flush request emits a partially filled word, so no data is stranded at end of packet.

---
 rtl/fifo_word_packer.sv | 122 ++++++++++++
 tb/tb_fifo_word_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains N-bit elements from a byte FIFO read port and
// packs K of them into one N*K-bit word on a valid/ready output. A flush
// pulse closes a partially filled word so nothing is stranded at end of packet.
module fifo_word_packer #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [N-1:0]         fifo_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*K-1:0]       out_data,
    output logic [$clog2(K):0]   out_count,
    output logic                 out_last
);

    localparam int CW = $clog2(K) + 1;
    localparam logic [CW-1:0] K_CNT = CW'(K);
    localparam logic [CW:0]   K_EXT = (CW+1)'(K);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           fill, fill_nx;
    logic                    pend;
    logic                    flush_req, flush_req_nx;
    logic [K-1:0][N-1:0]     lanes;
    logic [CW-1:0]           cnt_q;
    logic                    last_q;
    logic                    capture, close_full, close_flush, handshake;
    logic [CW:0]             fill_sum;

    // Next-state, read request and word-closing decisions.
    always_comb begin
        state_nx     = state;
        fill_nx      = fill;
        flush_req_nx = flush_req;
        capture      = 1'b0;
        close_full   = 1'b0;
        close_flush  = 1'b0;
        handshake    = 1'b0;
        fifo_rd_en   = 1'b0;
        // Count the in-flight element so fill can never exceed K.
        fill_sum     = {1'b0, fill} + (CW+1)'(pend);
        case (state)
            FILL: begin
                fifo_rd_en   = !rst && !fifo_empty && !flush_req && (fill_sum < K_EXT);
                flush_req_nx = flush_req | flush;
                if (pend) begin
                    capture = 1'b1;
                    fill_nx = fill + 1'b1;
                    if (fill_nx == K_CNT) begin
                        // A full word wins over a pending flush; the flush
                        // request survives into the next FILL.
                        close_full = 1'b1;
                        state_nx   = HOLD;
                    end
                end else if (flush_req && (fill != '0)) begin
                    close_flush  = 1'b1;
                    state_nx     = HOLD;
                    flush_req_nx = 1'b0;
                end else if (flush_req) begin
                    // Nothing captured and nothing in flight: drop the flush.
                    flush_req_nx = 1'b0;
                end
            end
            HOLD: begin
                flush_req_nx = flush_req | flush;
                if (out_ready) begin
                    handshake = 1'b1;
                    state_nx  = FILL;
                    fill_nx   = '0;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    // State, counters, lane capture and held word metadata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            fill      <= '0;
            pend      <= 1'b0;
            flush_req <= 1'b0;
            lanes     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            fill      <= fill_nx;
            pend      <= fifo_rd_en;
            flush_req <= flush_req_nx;
            if (capture) begin
                lanes[fill[CW-2:0]] <= fifo_data;
            end
            if (close_full) begin
                cnt_q  <= K_CNT;
                last_q <= 1'b0;
            end else if (close_flush) begin
                cnt_q  <= fill;
                last_q <= 1'b1;
            end
            // Clearing lanes on handshake keeps unused lanes of a partial word zero.
            if (handshake) begin
                lanes  <= '0;
                cnt_q  <= '0;
                last_q <= 1'b0;
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign out_data  = out_valid ? lanes : '0;
    assign out_count = cnt_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a small behavioural FIFO in front.
module tb_fifo_word_packer;

    localparam int N = 8;
    localparam int K = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic [N-1:0]   fifo_data;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [N*K-1:0] out_data;
    logic [2:0]     out_count;
    logic           out_last;

    logic           push_en;
    logic [7:0]     push_data;
    logic [7:0]     mem [256];
    logic [7:0]     wp = 8'd0;
    logic [7:0]     rp = 8'd0;
    int             rd_cnt = 0;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    fifo_word_packer #(.N(N), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_last   (out_last)
    );

    // Registered-output FIFO: data valid the cycle after rd_en, empty lags a pop.
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (push_en) begin
            mem[wp] <= push_data;
            wp      <= wp + 8'd1;
        end
        if (fifo_rd_en) begin
            fifo_data <= mem[rp];
            rp        <= rp + 8'd1;
            rd_cnt    <= rd_cnt + 1;
        end else begin
            fifo_data <= 'x;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        push_en   = 1'b1;
        push_data = d;
        @(negedge clk);
        push_en   = 1'b0;
    endtask

    task automatic wait_word(input string tag, input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input int cnt, input logic last);
        chk({tag, "_data"},  64'(out_data),  64'(d));
        chk({tag, "_count"}, 64'(out_count), 64'(cnt));
        chk({tag, "_last"},  64'(out_last),  64'(last));
    endtask

    initial begin
        int lat;
        int rb;
        int guard;

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        push_en   = 1'b0;
        push_data = 8'h00;
        @(negedge clk);
        @(negedge clk);

        // Reset state, with the FIFO preloaded so rd_en must be held off by rst.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("rst_rd_en",     64'(fifo_rd_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid),  64'd0);
        chk("rst_out_data",  64'(out_data),   64'd0);
        chk("rst_out_count", 64'(out_count),  64'd0);
        chk("rst_out_last",  64'(out_last),   64'd0);

        // Full word: four back-to-back reads, word visible K+1 cycles after first read.
        rst       = 1'b0;
        out_ready = 1'b1;
        wait_word("full", 20, lat);
        chk("full_latency", 64'(lat), 64'd5);
        chk_word("full", 32'h44332211, 4, 1'b0);
        chk("full_reads", 64'(rd_cnt), 64'd4);
        @(negedge clk);
        chk("full_valid_drop", 64'(out_valid), 64'd0);

        // Backpressure: second word waits in the FIFO while the first is held.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_word("bp1", 30, lat);
        chk_word("bp1", 32'h04030201, 4, 1'b0);
        rb = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid),  64'd1);
            chk("bp_hold_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        chk("bp_hold_data", 64'(out_data), 64'h04030201);
        chk("bp_hold_reads", 64'(rd_cnt), 64'(rb));
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        wait_word("bp2", 20, lat);
        chk_word("bp2", 32'h08070605, 4, 1'b0);
        @(negedge clk);

        // Partial flush after both elements are captured.
        push(8'hAA); push(8'hBB);
        repeat (4) @(negedge clk);
        chk("pf_no_early_word", 64'(out_valid), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_word("pf", 10, lat);
        chk_word("pf", 32'h0000BBAA, 2, 1'b1);
        @(negedge clk);
        chk("pf_valid_drop", 64'(out_valid), 64'd0);

        // Flush while the third element is still in flight.
        rb = rd_cnt;
        push(8'h31); push(8'h32); push(8'h33);
        guard = 0;
        while (rd_cnt != rb + 3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("inflight_reads", 64'(rd_cnt), 64'(rb + 3));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_word("inflight", 10, lat);
        chk_word("inflight", 32'h00333231, 3, 1'b1);
        @(negedge clk);

        // Empty flush is dropped and does not block the next word.
        rb = rd_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ef_no_word", 64'(out_valid), 64'd0);
        end
        chk("ef_no_reads", 64'(rd_cnt), 64'(rb));
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        wait_word("ef_next", 20, lat);
        chk_word("ef_next", 32'h54535251, 4, 1'b0);
        @(negedge clk);

        // Reset mid-fill discards the captured lanes.
        push(8'hE1); push(8'hE2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_valid", 64'(out_valid),  64'd0);
        chk("mr_data",  64'(out_data),   64'd0);
        chk("mr_count", 64'(out_count),  64'd0);
        chk("mr_last",  64'(out_last),   64'd0);
        chk("mr_rd_en", 64'(fifo_rd_en), 64'd0);
        rst = 1'b0;
        push(8'h77);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_word("mr_partial", 10, lat);
        chk_word("mr_partial", 32'h00000077, 1, 1'b1);
        @(negedge clk);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_word("mr_full", 20, lat);
        chk_word("mr_full", 32'h04030201, 4, 1'b0);
        @(negedge clk);
        chk("mr_valid_drop", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
